// File: rtl/scene_sequencer.sv
// Scene controller for the piano-keys game: sequences static screen drawers
// (screen 0 = home) and the live game source. It also muxes the active source onto
// one pixel bus for the VGA adapter, and guards each draw with a watchdog.
module scene_sequencer #(
  parameter int NUM_SCREENS = 3,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COL_W       = 3,
  parameter int TIMEOUT_CYC = 20000,
  localparam int SEL_W      = (NUM_SCREENS > 2) ? $clog2(NUM_SCREENS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         game_over,
  input  logic [SEL_W-1:0]             end_screen,
  input  logic [NUM_SCREENS-1:0]       scr_done,
  input  logic [NUM_SCREENS*X_W-1:0]   scr_x,
  input  logic [NUM_SCREENS*Y_W-1:0]   scr_y,
  input  logic [NUM_SCREENS*COL_W-1:0] scr_col,
  input  logic [X_W-1:0]               game_x,
  input  logic [Y_W-1:0]               game_y,
  input  logic [COL_W-1:0]             game_col,
  output logic [NUM_SCREENS-1:0]       scr_enable,
  output logic                         game_enable,
  output logic                         draw_enable,
  output logic [X_W-1:0]               x_out,
  output logic [Y_W-1:0]               y_out,
  output logic [COL_W-1:0]             col_out,
  output logic [SEL_W-1:0]             cur_screen,
  output logic                         timeout_err
);

  // Watchdog counts 0..TIMEOUT_CYC-1 inside one DRAW visit.
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {DRAW, SHOW, ARM, PLAY, OVER_WAIT} state_t;

  state_t            state_reg, state_next;
  logic [SEL_W-1:0]  cur_reg, cur_next;
  logic [SEL_W-1:0]  end_reg, end_next;
  logic [WD_W-1:0]   wd_reg, wd_next;
  logic              err_reg, err_next;

  logic [NUM_SCREENS-1:0] sel_onehot;
  logic [X_W-1:0]         x_slice   [NUM_SCREENS];
  logic [Y_W-1:0]         y_slice   [NUM_SCREENS];
  logic [COL_W-1:0]       col_slice [NUM_SCREENS];
  logic                   cur_done;
  logic                   wd_hit;
  logic [SEL_W-1:0]       end_clean;

  // Unpack per-drawer buses and decode the selected screen index.
  generate
    for (genvar gi = 0; gi < NUM_SCREENS; gi++) begin : g_slice
      assign sel_onehot[gi] = (cur_reg == SEL_W'(gi));
      assign x_slice[gi]    = scr_x[gi*X_W +: X_W];
      assign y_slice[gi]    = scr_y[gi*Y_W +: Y_W];
      assign col_slice[gi]  = scr_col[gi*COL_W +: COL_W];
    end
  endgenerate

  // Only the done bit of the screen being drawn matters.
  assign cur_done = |(scr_done & sel_onehot);
  assign wd_hit   = (TIMEOUT_CYC != 0) && (wd_reg == WD_W'(TIMEOUT_CYC - 1));

  // Home (0) and out-of-range indices are not valid end screens; fall back to 1.
  assign end_clean = ((end_screen == '0) ||
                      ({1'b0, end_screen} >= (SEL_W+1)'(NUM_SCREENS)))
                     ? SEL_W'(1) : end_screen;

  assign cur_screen  = cur_reg;
  assign timeout_err = err_reg;

  // State and datapath registers; async reset lands in DRAW of the home screen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= DRAW;
      cur_reg   <= '0;
      end_reg   <= SEL_W'(1);
      wd_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      end_reg   <= end_next;
      wd_reg    <= wd_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic plus Moore decode of enables and the pixel mux.
  always_comb begin
    state_next  = state_reg;
    cur_next    = cur_reg;
    end_next    = end_reg;
    wd_next     = '0;
    err_next    = err_reg;
    scr_enable  = '0;
    game_enable = 1'b0;
    draw_enable = 1'b0;
    x_out       = '0;
    y_out       = '0;
    col_out     = '0;
    case (state_reg)
      DRAW: begin
        scr_enable  = sel_onehot;
        draw_enable = 1'b1;
        x_out       = x_slice[cur_reg];
        y_out       = y_slice[cur_reg];
        col_out     = col_slice[cur_reg];
        wd_next     = wd_reg + WD_W'(1);
        if (cur_done) begin
          state_next = SHOW;
          wd_next    = '0;
        end else if (wd_hit) begin
          state_next = SHOW;
          wd_next    = '0;
          err_next   = 1'b1;
        end
      end
      SHOW: begin
        if (start) state_next = ARM;
      end
      ARM: begin
        if (!start) state_next = PLAY;
      end
      PLAY: begin
        game_enable = 1'b1;
        draw_enable = 1'b1;
        x_out       = game_x;
        y_out       = game_y;
        col_out     = game_col;
        if (game_over) begin
          state_next = OVER_WAIT;
          end_next   = end_clean;
        end
      end
      OVER_WAIT: begin
        if (!game_over) begin
          state_next = DRAW;
          cur_next   = end_reg;
        end
      end
      default: state_next = DRAW;
    endcase
  end

endmodule
